image_stream_proc: RTL and testbench

Parametrised successor to the image reader. Fetches an RGB frame from an external synchronous frame-buffer RAM and applies a run-time-selected point operation: pass, brightness, invert or threshold. Streams PPC pixels per beat over a valid/ready interface and generates VSYNC/HSYNC framing and a done pulse. Sits between the frame buffer and the downstream writer/display path.

---
 rtl/img_pkg.sv | 22 ++
 rtl/image_stream_proc_pix_op.sv | 51 +++++
 rtl/image_stream_proc.sv | 207 ++++++++++++++++++++
 tb/tb_image_stream_proc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared encodings for the image stream processor: point-operation modes and
// frame-sequencer states.
package img_pkg;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_BRIGHT = 2'd1;
    localparam logic [1:0] MODE_INVERT = 2'd2;
    localparam logic [1:0] MODE_THRESH = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_LINE    = 3'd2,
        ST_HBLANK  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/image_stream_proc_pix_op.sv
// Combinational single-pixel point operator on an {R,G,B} triple.
module pix_op
    import img_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [1:0]      mode,
    input  logic            sign,
    input  logic [DW-1:0]   brightness,
    input  logic [DW-1:0]   threshold,
    input  logic [3*DW-1:0] pix_in,
    output logic [3*DW-1:0] pix_out
);

    localparam logic [DW-1:0] MAXV = {DW{1'b1}};

    logic [DW-1:0] ch_s;
    logic [DW-1:0] res_s;
    logic [DW:0]   wide_s;
    logic [DW+1:0] sum_s;
    logic [DW+1:0] thr3_s;

    // Per-channel operation; threshold compares the channel sum at DW+2 bits
    always_comb begin
        sum_s   = {2'b00, pix_in[3*DW-1 -: DW]} + {2'b00, pix_in[2*DW-1 -: DW]} + {2'b00, pix_in[DW-1:0]};
        thr3_s  = {2'b00, threshold} + {2'b00, threshold} + {2'b00, threshold};
        ch_s    = '0;
        res_s   = '0;
        wide_s  = '0;
        pix_out = '0;
        for (int i = 0; i < 3; i++) begin
            ch_s   = pix_in[i*DW +: DW];
            wide_s = {1'b0, ch_s} + {1'b0, brightness};
            case (mode)
                MODE_PASS:   res_s = ch_s;
                MODE_BRIGHT: begin
                    if (sign) begin
                        res_s = wide_s[DW] ? MAXV : wide_s[DW-1:0];
                    end else begin
                        res_s = (ch_s > brightness) ? (ch_s - brightness) : '0;
                    end
                end
                MODE_INVERT: res_s = MAXV - ch_s;
                MODE_THRESH: res_s = (sum_s > thr3_s) ? MAXV : '0;
                default:     res_s = ch_s;
            endcase
            pix_out[i*DW +: DW] = res_s;
        end
    end

endmodule

// File: rtl/image_stream_proc.sv
// Frame-buffer reader with run-time point operation, credit-limited read
// pipeline into a 4-entry output FIFO, and VSYNC/HSYNC framing.
module image_stream_proc
    import img_pkg::*;
#(
    parameter int WIDTH         = 768,
    parameter int HEIGHT        = 512,
    parameter int PPC           = 2,
    parameter int DW            = 8,
    parameter int STARTUP_DELAY = 100,
    parameter int HSYNC_DELAY   = 160,
    parameter int AW            = $clog2(WIDTH*HEIGHT/PPC)
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                sign,
    input  logic [DW-1:0]       brightness,
    input  logic [DW-1:0]       threshold,
    output logic                mem_rd,
    output logic [AW-1:0]       mem_addr,
    input  logic [PPC*3*DW-1:0] mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PPC*3*DW-1:0] out_data,
    output logic                HSYNC,
    output logic                VSYNC,
    output logic                busy,
    output logic                ctrl_done
);

    localparam int BEATS = WIDTH / PPC;
    localparam int PW    = 3 * DW;
    localparam int BW    = PPC * PW;
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int LCW   = $clog2(HEIGHT + 1);
    localparam int DCW   = $clog2(max_int(STARTUP_DELAY, HSYNC_DELAY) + 1);

    state_t          state_r, state_s;
    logic [DCW-1:0]  dly_r;
    logic [BCW-1:0]  issued_r, issued_base_s, issued_next_s, acc_r;
    logic [LCW-1:0]  line_r;
    logic            rd_r, rd_next_s, v1_r, any_rd_r;
    logic [AW-1:0]   addr_r;
    logic [1:0]      mode_r;
    logic            sign_r;
    logic [DW-1:0]   bright_r, thresh_r;
    logic [BW-1:0]   fifo_r [4];
    logic [1:0]      wr_ptr_r, rd_ptr_r;
    logic [2:0]      cnt_r, cnt_next_s;
    logic            push_s, pop_s, last_beat_s, last_line_s;
    logic            hsync_r, vsync_r, busy_r, done_r;
    logic [BW-1:0]   proc_s;

    for (genvar k = 0; k < PPC; k++) begin : g_pix
        pix_op #(.DW(DW)) u_pix_op (
            .mode       (mode_r),
            .sign       (sign_r),
            .brightness (bright_r),
            .threshold  (thresh_r),
            .pix_in     (mem_rdata[k*PW +: PW]),
            .pix_out    (proc_s[k*PW +: PW])
        );
    end

    assign push_s      = v1_r;
    assign pop_s       = (cnt_r != 3'd0) && out_ready;
    assign cnt_next_s  = cnt_r + {2'b00, push_s} - {2'b00, pop_s};
    assign last_beat_s = pop_s && (acc_r == BCW'(BEATS - 1));
    assign last_line_s = (line_r == LCW'(HEIGHT - 1));

    // Next-state logic of the frame sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_STARTUP;
                else       state_s = ST_IDLE;
            end
            ST_STARTUP: begin
                if (dly_r == DCW'(STARTUP_DELAY - 1)) state_s = ST_LINE;
                else                                  state_s = ST_STARTUP;
            end
            ST_LINE: begin
                if (last_beat_s) state_s = last_line_s ? ST_DONE : ST_HBLANK;
                else             state_s = ST_LINE;
            end
            ST_HBLANK: begin
                if (dly_r == DCW'(HSYNC_DELAY - 1)) state_s = ST_LINE;
                else                                state_s = ST_HBLANK;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Read issue is decided a cycle early so mem_rd is a flop; credit is
    // next-cycle FIFO occupancy plus the read whose data arrives then
    always_comb begin
        issued_base_s = (state_r == ST_LINE) ? issued_r : '0;
        rd_next_s     = 1'b0;
        issued_next_s = '0;
        if (state_s == ST_LINE) begin
            if ((issued_base_s < BCW'(BEATS)) && (({1'b0, cnt_next_s} + {3'b000, rd_r}) < 4'd4)) begin
                rd_next_s = 1'b1;
            end else begin
                rd_next_s = 1'b0;
            end
            issued_next_s = issued_base_s + {{(BCW-1){1'b0}}, rd_next_s};
        end else begin
            issued_next_s = '0;
        end
    end

    // Sequencer state, delay/line/beat counters and parameter latch
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r  <= ST_IDLE;
            dly_r    <= '0;
            acc_r    <= '0;
            line_r   <= '0;
            mode_r   <= MODE_PASS;
            sign_r   <= 1'b0;
            bright_r <= '0;
            thresh_r <= '0;
        end else begin
            state_r <= state_s;
            if ((state_s != state_r) || !((state_r == ST_STARTUP) || (state_r == ST_HBLANK))) dly_r <= '0;
            else dly_r <= dly_r + 1'b1;
            if (state_r != ST_LINE) acc_r <= '0;
            else if (pop_s)         acc_r <= last_beat_s ? '0 : acc_r + 1'b1;
            if (state_r == ST_IDLE)                   line_r <= '0;
            else if (state_r == ST_LINE && last_beat_s) line_r <= line_r + 1'b1;
            if (state_r == ST_IDLE && start) begin
                mode_r   <= mode;
                sign_r   <= sign;
                bright_r <= brightness;
                thresh_r <= threshold;
            end
        end
    end

    // Read pipeline: strobe, data-valid stage and frame-contiguous address
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_r     <= 1'b0;
            v1_r     <= 1'b0;
            issued_r <= '0;
            addr_r   <= '0;
            any_rd_r <= 1'b0;
        end else begin
            rd_r     <= rd_next_s;
            v1_r     <= rd_r;
            issued_r <= issued_next_s;
            if (state_r == ST_IDLE && start) begin
                addr_r   <= '0;
                any_rd_r <= 1'b0;
            end else if (rd_next_s) begin
                if (any_rd_r) addr_r <= addr_r + 1'b1;
                any_rd_r <= 1'b1;
            end
        end
    end

    // Output FIFO; the credit check above guarantees it never overflows
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < 4; i++) fifo_r[i] <= '0;
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            cnt_r    <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= proc_s;
                wr_ptr_r         <= wr_ptr_r + 2'd1;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
            cnt_r <= cnt_next_s;
        end
    end

    // Framing/status flops track the upcoming state so they align with it
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hsync_r <= 1'b0;
            vsync_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            hsync_r <= (state_s == ST_LINE);
            vsync_r <= (state_s == ST_LINE) || (state_s == ST_HBLANK);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign mem_rd    = rd_r;
    assign mem_addr  = addr_r;
    assign out_valid = (cnt_r != 3'd0);
    assign out_data  = fifo_r[rd_ptr_r];
    assign HSYNC     = hsync_r;
    assign VSYNC     = vsync_r;
    assign busy      = busy_r;
    assign ctrl_done = done_r;

endmodule

// File: tb/tb_image_stream_proc.sv
// Scoreboard bench for image_stream_proc: directed frames with hand-computed
// expected beats, checked by an independent output monitor.
module tb_image_stream_proc;

    localparam int AW = 3;
    localparam int BW = 48;

    logic          HCLK = 1'b0, HRESET = 1'b1, start = 1'b0, sign = 1'b0, out_ready = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    brightness = 8'd0, threshold = 8'd0;
    logic          mem_rd, out_valid, HSYNC, VSYNC, busy, ctrl_done;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_rdata = '0, out_data, held = '0;
    logic [BW-1:0] ram [8];
    logic [BW-1:0] exp_q [$];

    int checks = 0, fails = 0, cyc = 0, rdy_mode = 0;
    int hs_cycles = 0, hs_windows = 0, done_cnt = 0, first_rd = -1, done_cyc = -1;
    int start_cyc = 0, exp_addr = 0, rd_total = 0, acc_total = 0;
    logic hs_prev = 1'b0, stall_prev = 1'b0;

    image_stream_proc #(
        .WIDTH(8), .HEIGHT(2), .PPC(2), .DW(8), .STARTUP_DELAY(4), .HSYNC_DELAY(3)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .sign(sign),
        .brightness(brightness), .threshold(threshold), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .busy(busy), .ctrl_done(ctrl_done)
    );

    initial forever #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Synchronous frame-buffer RAM: data one cycle after the strobe
    always @(posedge HCLK) if (mem_rd) mem_rdata <= ram[mem_addr];

    initial forever begin
        @(posedge HCLK); #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, address sequence, credit limit, stall stability, framing stats
    always @(negedge HCLK) begin
        if (HRESET) begin
            hs_cycles = 0; hs_windows = 0; done_cnt = 0; first_rd = -1; done_cyc = -1;
            exp_addr = 0; rd_total = 0; acc_total = 0; hs_prev = 1'b0; stall_prev = 1'b0;
        end else begin
            if (start && !busy) begin
                hs_cycles = 0; hs_windows = 0; done_cnt = 0; first_rd = -1; done_cyc = -1;
                exp_addr = 0; rd_total = 0; acc_total = 0; start_cyc = cyc;
            end
            if (mem_rd) begin
                check("mem_addr", 64'(mem_addr), 64'(exp_addr));
                if (first_rd < 0) first_rd = cyc;
                exp_addr++;
                rd_total++;
                check("outstanding_le4", 64'(rd_total - acc_total <= 4), 64'd1);
            end
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_stable", 64'(out_data), 64'(held));
            end
            stall_prev = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                acc_total++;
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL extra_beat: got %0h, expected no beat", out_data);
                end else begin
                    check("beat", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
            if (HSYNC) hs_cycles++;
            if (HSYNC && !hs_prev) hs_windows++;
            hs_prev = HSYNC;
            if (ctrl_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic fill_pass();
        logic [7:0] v;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            v = 8'(i);
            ram[i] = {6{v}};
            exp_q.push_back({6{v}});
        end
    endtask

    task automatic fill_ab(input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] ea, input logic [23:0] eb);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            ram[i] = {b, a};
            exp_q.push_back({eb, ea});
        end
    endtask

    // Start a frame, then scramble the inputs to prove they were latched
    task automatic start_frame(input logic [1:0] m, input logic s, input logic [7:0] b, input logic [7:0] t);
        @(posedge HCLK); #1;
        mode = m; sign = s; brightness = b; threshold = t; start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0; mode = ~m; sign = ~s; brightness = ~b; threshold = ~t;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (ctrl_done !== 1'b1 && n < 1000) begin
            @(negedge HCLK);
            n++;
        end
        check({name, "_done_seen"}, 64'(n < 1000), 64'd1);
        repeat (3) @(negedge HCLK);
        check({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done_count"}, 64'(done_cnt), 64'd1);
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic frame_stats(input string name);
        check({name, "_hsync_cycles"}, 64'(hs_cycles), 64'd12);
        check({name, "_hsync_windows"}, 64'(hs_windows), 64'd2);
        check({name, "_first_rd_lat"}, 64'(first_rd - start_cyc), 64'd5);
        check({name, "_frame_time"}, 64'(done_cyc - start_cyc), 64'd20);
        check({name, "_reads"}, 64'(rd_total), 64'd8);
        check({name, "_addr_hold"}, 64'(mem_addr), 64'd7);
    endtask

    initial begin
        int r0;
        int n;
        repeat (3) @(posedge HCLK);
        #1;
        check("reset_outputs", 64'({mem_rd, mem_addr, out_valid, out_data, HSYNC, VSYNC, busy, ctrl_done}), 64'd0);
        HRESET = 1'b0;

        fill_pass();
        start_frame(2'd0, 1'b0, 8'd0, 8'd0);
        wait_done("pass");
        frame_stats("pass");

        fill_ab(24'hC83200, 24'h0A141E, 24'hFF9664, 24'h6E7882);
        start_frame(2'd1, 1'b1, 8'd100, 8'd0);
        wait_done("bright_add");

        fill_ab(24'hC83200, 24'h966463, 24'h640000, 24'h320000);
        start_frame(2'd1, 1'b0, 8'd100, 8'd0);
        wait_done("bright_sub");

        fill_ab(24'h5A5A5B, 24'h5A5A5A, 24'hFFFFFF, 24'h000000);
        start_frame(2'd3, 1'b0, 8'd0, 8'd90);
        wait_done("thresh");

        fill_ab(24'h0080FF, 24'h010203, 24'hFF7F00, 24'hFEFDFC);
        start_frame(2'd2, 1'b0, 8'd0, 8'd0);
        wait_done("invert");

        fill_pass();
        rdy_mode = 1;
        start_frame(2'd0, 1'b0, 8'd0, 8'd0);
        repeat (15) @(negedge HCLK);
        rdy_mode = 2;
        repeat (8) @(negedge HCLK);
        r0 = rd_total;
        repeat (12) @(negedge HCLK);
        check("stall_no_reads", 64'(rd_total), 64'(r0));
        check("stall_pending", 64'(out_valid), 64'd1);
        rdy_mode = 0;
        wait_done("stall");

        fill_pass();
        start_frame(2'd0, 1'b0, 8'd0, 8'd0);
        n = 0;
        while (hs_windows < 2 && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        check("reach_line1", 64'(n < 200), 64'd1);
        repeat (2) @(negedge HCLK);
        #2 HRESET = 1'b1;
        #1 check("async_reset", 64'({mem_rd, mem_addr, out_valid, out_data, HSYNC, VSYNC, busy, ctrl_done}), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge HCLK);
        #3 HRESET = 1'b0;
        repeat (4) @(negedge HCLK);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        fill_pass();
        start_frame(2'd0, 1'b0, 8'd0, 8'd0);
        wait_done("after_reset");
        frame_stats("after_reset");

        fill_ab(24'hC83200, 24'h0A141E, 24'hFF9664, 24'h6E7882);
        start_frame(2'd1, 1'b1, 8'd100, 8'd0);
        repeat (8) @(negedge HCLK);
        @(posedge HCLK); #1;
        mode = 2'd2; sign = 1'b0; brightness = 8'd50; start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
        wait_done("start_busy");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
